// File: rtl/rx_cmd_fifo_pkg.sv
// rtl/rx_cmd_fifo_pkg.sv - shared types and constants for the receive command queue
//
// Purpose: output FSM state encoding, the ASCII codes that drive byte
// classification, the error counter ceiling and the classification helpers.
// Ports: none (package).
package rx_cmd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_0       = 8'h30;
  localparam logic [7:0] ASCII_9       = 8'h39;
  localparam logic [7:0] ASCII_FLUSH_U = 8'h58;
  localparam logic [7:0] ASCII_FLUSH_L = 8'h78;

  localparam logic [7:0] ERR_MAX = 8'hFF;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  function automatic logic is_flush(input logic [7:0] b);
    return (b == ASCII_FLUSH_U) || (b == ASCII_FLUSH_L);
  endfunction

endpackage

// File: rtl/rx_cmd_fifo_if.sv
// rtl/rx_cmd_fifo_if.sv - byte input and strobe/status output bundle of rx_cmd_fifo
//
// Purpose: groups the receiver-side strobe and the downstream strobe/status
// signals so the block and its users share one declaration.
// Ports (signals):
//   i_Rcv, i_Ascii        byte strobe and received byte (into the block)
//   o_Enable, o_Dec       digit strobe and value to data_state_machine
//   o_Count/o_Full/o_Empty queue occupancy and flags
//   o_Drop, o_Err_cnt     discard pulse and saturating discard count
// Modports: master drives the inputs (receiver/bench), slave is the block.
interface rx_cmd_fifo_if #(
  parameter int DEPTH = 8
);

  logic                   i_Rcv;
  logic [7:0]             i_Ascii;
  logic                   o_Enable;
  logic [3:0]             o_Dec;
  logic [$clog2(DEPTH):0] o_Count;
  logic                   o_Full;
  logic                   o_Empty;
  logic                   o_Drop;
  logic [7:0]             o_Err_cnt;

  modport master (
    output i_Rcv, i_Ascii,
    input  o_Enable, o_Dec, o_Count, o_Full, o_Empty, o_Drop, o_Err_cnt
  );

  modport slave (
    input  i_Rcv, i_Ascii,
    output o_Enable, o_Dec, o_Count, o_Full, o_Empty, o_Drop, o_Err_cnt
  );

endinterface

// File: rtl/rx_cmd_fifo_sync_fifo_4b.sv
// rtl/rx_cmd_fifo_sync_fifo_4b.sv - DEPTH-entry 4-bit synchronous FIFO with flush
//
// Purpose: generic nibble queue; also intended for a later TX status queue.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, wdata   write request and data; accepted when not full or when a
//                 pop happens in the same cycle
//   pop, rdata    read request and head-of-queue data (combinational)
//   flush         clears the queue; overrides push and pop
//   count         occupancy, full = count==DEPTH, empty = count==0
module sync_fifo_4b #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [3:0]             wdata,
  output logic [3:0]             rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = mem[rd_ptr];

  // A full queue can still take a write when the head leaves in the same cycle.
  assign rd_en = pop && !empty && !flush;
  assign wr_en = push && (!full || rd_en) && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rx_cmd_fifo.sv
// rtl/rx_cmd_fifo.sv - filters received ASCII into a digit queue and replays it as spaced strobes
//
// Purpose: digits are queued, 'X'/'x' flushes the queue, any other byte (or a
// digit arriving at a full queue with no pop) is dropped and counted. Queued
// digits leave as one-cycle o_Enable strobes at least GAP+2 cycles apart.
// Ports:
//   i_Clk, i_Rst  clock, synchronous active-high reset
//   bus           rx_cmd_fifo_if slave: i_Rcv/i_Ascii in; o_Enable, o_Dec,
//                 o_Count, o_Full, o_Empty, o_Drop, o_Err_cnt out
module rx_cmd_fifo
  import rx_cmd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GAP   = 4
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  rx_cmd_fifo_if.slave bus
);

  // Counter only ever holds GAP-1 down to 0.
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t        state;
  state_t        next_state;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] next_gap_cnt;
  logic          enable;

  logic          rcv_digit;
  logic          rcv_flush;
  logic          pop;
  logic          push;
  logic          drop;
  logic [3:0]    head;

  assign rcv_digit = bus.i_Rcv && is_digit(bus.i_Ascii);
  assign rcv_flush = bus.i_Rcv && is_flush(bus.i_Ascii);

  // Digits 0x30..0x39 carry their value in the low nibble.
  assign push = rcv_digit && (!bus.o_Full || pop);
  assign drop = bus.i_Rcv && !rcv_flush && !push;

  sync_fifo_4b #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (i_Clk),
    .rst  (i_Rst),
    .push (push),
    .pop  (pop),
    .flush(rcv_flush),
    .wdata(bus.i_Ascii[3:0]),
    .rdata(head),
    .count(bus.o_Count),
    .full (bus.o_Full),
    .empty(bus.o_Empty)
  );

  always_comb begin
    next_state   = state;
    next_gap_cnt = gap_cnt;
    pop          = 1'b0;
    enable       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!bus.o_Empty && !rcv_flush) begin
          pop        = 1'b1;
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        enable = 1'b1;
        if (GAP > 0) begin
          next_state   = S_GAP;
          next_gap_cnt = GW'(GAP - 1);
        end else begin
          next_state = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) next_state = S_IDLE;
        else               next_gap_cnt = gap_cnt - 1'b1;
      end
      default: next_state = S_IDLE;
    endcase
    // A flush abandons any pending gap, but a strobe already on the wire finishes.
    if (rcv_flush && state != S_ISSUE) next_state = S_IDLE;
  end

  assign bus.o_Enable = enable;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state         <= S_IDLE;
      gap_cnt       <= '0;
      bus.o_Dec     <= '0;
      bus.o_Drop    <= 1'b0;
      bus.o_Err_cnt <= '0;
    end else begin
      state      <= next_state;
      gap_cnt    <= next_gap_cnt;
      bus.o_Drop <= drop;
      if (pop) bus.o_Dec <= head;
      if (drop && bus.o_Err_cnt != ERR_MAX) bus.o_Err_cnt <= bus.o_Err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_rx_cmd_fifo.sv
// tb/tb_rx_cmd_fifo.sv - self-checking bench for rx_cmd_fifo
module tb_rx_cmd_fifo;

  localparam int DEPTH = 8;
  localparam int GAP   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rx_cmd_fifo_if #(.DEPTH(DEPTH)) bus ();

  rx_cmd_fifo #(
    .DEPTH(DEPTH),
    .GAP  (GAP)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a digit queue plus the earliest cycle a pop may happen.
  int q[$];
  int next_pop  = 0;
  int last_pop  = -100;
  int m_en      = 0;
  int m_dec     = 0;
  int m_drop    = 0;
  int m_err     = 0;

  int s_cyc[$];
  int s_val[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic rcv, input logic [7:0] ascii);
    bit is_d, is_f, pop_now, acc;
    rst         = r;
    bus.i_Rcv   = rcv;
    bus.i_Ascii = ascii;
    if (r) begin
      q.delete();
      m_en = 0; m_dec = 0; m_drop = 0; m_err = 0;
      next_pop = cyc + 1;
      last_pop = -100;
    end else begin
      is_d    = rcv && (ascii >= 8'h30) && (ascii <= 8'h39);
      is_f    = rcv && (ascii == 8'h58 || ascii == 8'h78);
      pop_now = (q.size() > 0) && (cyc >= next_pop) && !is_f;
      acc     = is_d && ((q.size() < DEPTH) || pop_now);
      m_drop  = (rcv && !is_f && !acc) ? 1 : 0;
      if (m_drop == 1 && m_err < 255) m_err++;
      m_en = pop_now ? 1 : 0;
      if (pop_now) begin
        m_dec    = q.pop_front();
        next_pop = cyc + GAP + 2;
        last_pop = cyc;
      end
      if (acc) q.push_back(int'(ascii) - 48);
      if (is_f) begin
        q.delete();
        if (last_pop != cyc - 1) next_pop = cyc + 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (bus.o_Enable === 1'b1) begin
      s_cyc.push_back(cyc);
      s_val.push_back(int'(bus.o_Dec));
    end
    check("enable", 32'(bus.o_Enable), 32'(m_en));
    check("dec",    32'(bus.o_Dec),    32'(m_dec));
    check("count",  32'(bus.o_Count),  32'(q.size()));
    check("full",   32'(bus.o_Full),   32'(q.size() == DEPTH));
    check("empty",  32'(bus.o_Empty),  32'(q.size() == 0));
    check("drop",   32'(bus.o_Drop),   32'(m_drop));
    check("err",    32'(bus.o_Err_cnt), 32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int base;
    int err0;
    int r;
    bus.i_Rcv   = 1'b0;
    bus.i_Ascii = 8'h00;

    // 1. reset for three cycles
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    idle(2);

    // 2. '1','2','3' back to back -> strobes at +2, +8, +14
    s_cyc.delete(); s_val.delete();
    base = cyc;
    step(1'b0, 1'b1, 8'h31);
    step(1'b0, 1'b1, 8'h32);
    step(1'b0, 1'b1, 8'h33);
    idle(20);
    check("t2_nstrobes", 32'(s_cyc.size()), 32'd3);
    for (int i = 0; i < s_cyc.size() && i < 3; i++) begin
      check("t2_strobe_cycle", 32'(s_cyc[i] - base), 32'(2 + 6 * i));
      check("t2_strobe_value", 32'(s_val[i]), 32'(i + 1));
    end

    // 3. 'A' is dropped
    s_cyc.delete(); s_val.delete();
    step(1'b0, 1'b1, 8'h41);
    check("t3_drop_pulse", 32'(bus.o_Drop), 32'd1);
    check("t3_err", 32'(bus.o_Err_cnt), 32'd1);
    idle(3);
    check("t3_nstrobes", 32'(s_cyc.size()), 32'd0);

    // 4. overflow with 12 digits
    s_cyc.delete(); s_val.delete();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'(48 + (i % 10)));
    check("t4_err", 32'(bus.o_Err_cnt), 32'd3);
    idle(70);
    check("t4_nstrobes", 32'(s_cyc.size()), 32'd10);
    for (int i = 0; i < s_val.size() && i < 10; i++)
      check("t4_order", 32'(s_val[i]), 32'(i));

    // 5. flush right after the first strobe
    s_cyc.delete(); s_val.delete();
    err0 = int'(bus.o_Err_cnt);
    step(1'b0, 1'b1, 8'h34);
    step(1'b0, 1'b1, 8'h35);
    step(1'b0, 1'b1, 8'h36);
    step(1'b0, 1'b1, 8'h78);
    check("t5_count", 32'(bus.o_Count), 32'd0);
    idle(20);
    check("t5_nstrobes", 32'(s_cyc.size()), 32'd1);
    check("t5_err", 32'(bus.o_Err_cnt), 32'(err0));

    // 6. reset in the cycle after the second strobe, three digits still queued
    s_cyc.delete(); s_val.delete();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(49 + i));
    idle(4);
    check("t6_pre_count", 32'(bus.o_Count), 32'd3);
    step(1'b1, 1'b0, 8'h00);
    check("t6_count", 32'(bus.o_Count), 32'd0);
    check("t6_enable", 32'(bus.o_Enable), 32'd0);
    idle(20);
    check("t6_nstrobes", 32'(s_cyc.size()), 32'd2);

    // 7. error counter saturation
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 8'h41);
    check("t7_err_sat", 32'(bus.o_Err_cnt), 32'd255);
    idle(2);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45)      step(1'b0, 1'b1, 8'(48 + $urandom_range(0, 9)));
      else if (r < 49) step(1'b0, 1'b1, ($urandom_range(0, 1) != 0) ? 8'h58 : 8'h78);
      else if (r < 57) step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
      else if (r < 58) step(1'b1, 1'b0, 8'h00);
      else             step(1'b0, 1'b0, 8'h00);
    end
    idle(80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_cmd_fifo.md
Name: rx_cmd_fifo

Overview:
- Sits between uart_rx/ascii_to_dec and data_state_machine.
- Accepts raw ASCII bytes strobed by the UART receiver and filters them: decimal digits are queued, a flush character clears the queue, and everything else is dropped and counted.
- Replays queued digits to data_state_machine as single-cycle i_Enable/i_Dec strobes, spaced at a guaranteed minimum distance.
- Absorbs bursty serial traffic (pasted command strings) so no digit is lost while the downstream FSM and motors are busy.

Parameters:
- DEPTH, 8: FIFO entries. Power of two, at least 2.
- GAP, 4: idle cycles inserted after each output strobe. 0 is legal.

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  reset, synchronous, active-high
- i_Rcv  in  1  one-cycle strobe, i_Ascii valid
- i_Ascii  in  8  received ASCII byte
- o_Enable  out  1  one-cycle strobe to data_state_machine i_Enable
- o_Dec  out  4  digit value, valid while o_Enable=1; holds its last value otherwise
- o_Count  out  $clog2(DEPTH)+1  current occupancy
- o_Full  out  1  o_Count==DEPTH
- o_Empty  out  1  o_Count==0
- o_Drop  out  1  one-cycle pulse when a received byte is discarded
- o_Err_cnt  out  8  discarded-byte count, saturates at 255

Behaviour:
- Clock and reset: one clock domain, i_Clk. i_Rst is synchronous and active-high. All state is updated on the rising edge.
- Reset values: FIFO pointers=0, o_Count=0, o_Empty=1, o_Full=0, o_Enable=0, o_Dec=0, o_Drop=0, o_Err_cnt=0, FSM=S_IDLE.
- Input classification (only when i_Rcv=1):
  - 0x30..0x39: push i_Ascii-0x30.
  - 0x58 ('X') or 0x78 ('x'): flush.
  - Any other byte: drop.
- Push rules:
  - Not full: accepted; o_Count increments at the edge.
  - Full with a pop in the same cycle: accepted; o_Count unchanged.
  - Full with no pop: dropped.
- Drop: o_Drop=1 in the following cycle (registered). o_Err_cnt += 1, saturating at 255.
- Flush: read and write pointers are cleared at the edge and o_Count=0 next cycle. A pop in the same cycle is cancelled. A strobe already in S_ISSUE completes normally. The FSM goes to S_IDLE unless it is in S_ISSUE, in which case it follows its normal path. A flush does not count as a drop.
- Output FSM:
  - S_IDLE: if !o_Empty, pop the head into the o_Dec register and go to S_ISSUE.
  - S_ISSUE: o_Enable=1 for exactly one cycle. If GAP>0, go to S_GAP and load the gap counter with GAP-1; if GAP=0, go to S_IDLE.
  - S_GAP: decrement the counter; at 0, go to S_IDLE.
- Latency and spacing:
  - i_Rcv of a digit in cycle N into an empty, idle block gives o_Enable in cycle N+2.
  - Minimum spacing between consecutive o_Enable pulses is GAP+2 cycles.
- Ordering: strict FIFO, and no value is ever duplicated.
- Pointers: log2(DEPTH) bits and wrap naturally. Occupancy is tracked by a separate counter.
- Reset mid-operation: a reset in any state, including mid-GAP or mid-ISSUE, returns all outputs to their reset values in the next cycle and discards the queue contents.

Decomposition:
- Package rx_cmd_pkg:
  - state_t enum {S_IDLE, S_ISSUE, S_GAP}
  - ASCII_0=8'h30, ASCII_9=8'h39, ASCII_FLUSH_U=8'h58, ASCII_FLUSH_L=8'h78
  - ERR_MAX=8'hFF
- Sub-module sync_fifo_4b:
  - DEPTH-parameterised 4-bit synchronous FIFO with push, pop and flush inputs, and count/full/empty outputs.
  - It is reusable for a later TX status queue.
- Classification and the output FSM stay in rx_cmd_fifo.

Test Plan:
1. Reset: assert i_Rst for 3 cycles, then release -> o_Empty=1, o_Count=0, o_Enable=0, o_Dec=0, o_Err_cnt=0.
2. Digits '1','2','3' (0x31,0x32,0x33) on i_Rcv in cycles 0,1,2, GAP=4 -> o_Enable in cycles 2, 8 and 14 with o_Dec 1, 2 and 3; no other strobes.
3. Byte 0x41 ('A') -> o_Drop pulse in the following cycle, o_Count=0, o_Err_cnt=1, no o_Enable.
4. Overflow: 12 back-to-back digits 0..9,0,1 starting at cycle 0, DEPTH=8, GAP=4 -> o_Full=1 after cycle 9, bytes 10 and 11 dropped (o_Err_cnt=2), and exactly 10 strobes carrying 0..9 in order.
5. Flush: queue '4','5','6', then send 'x' in the cycle after the first strobe -> o_Count=0 next cycle, no strobes for 5 and 6, o_Err_cnt unchanged.
6. Reset mid-GAP: assert i_Rst in the cycle after a strobe with 3 digits still queued -> next cycle o_Count=0 and o_Enable=0, and no strobes follow.
7. Saturation: 300 bytes of 0x41 -> o_Err_cnt holds at 255 with no wrap.
